// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store queue: FSM states, access width and
// command encodings, plus a byte-lane selection helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } lsu_state_e;

    typedef enum logic {
        WIDTH_16 = 1'b0,
        WIDTH_8  = 1'b1
    } width_e;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    function automatic logic [7:0] laneSelect(input logic [15:0] word, input logic hiLane);
        return hiLane ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/lsu_q_if.sv
// Request and memory-beat signal bundle for the load/store queue.
// The slave modport is the queue itself; the master modport is whoever
// issues requests and models the memory.
interface lsu_q_if #(
    parameter int ADDR_W = 16,
    parameter int TAG_W  = 2
);
    logic [ADDR_W-1:0] rq_addr;
    logic [15:0]       rq_data;
    logic              rq_width;
    logic              rq_cmd;
    logic [TAG_W-1:0]  rq_tag;
    logic              rq_start;
    logic              rq_hold;

    logic              mem_rdy;
    logic [15:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_cmd;
    logic              be0;
    logic              be1;
    logic              mem_assert;

    logic              rs_wb;
    logic              rs_ld;
    logic [TAG_W-1:0]  rs_tag;
    logic [15:0]       rs_data;

    modport slave (
        input  rq_addr, rq_data, rq_width, rq_cmd, rq_tag, rq_start,
        output rq_hold,
        input  mem_rdy, mem_rdata,
        output mem_addr, mem_data, mem_cmd, be0, be1, mem_assert,
        output rs_wb, rs_ld, rs_tag, rs_data
    );

    modport master (
        output rq_addr, rq_data, rq_width, rq_cmd, rq_tag, rq_start,
        input  rq_hold,
        output mem_rdy, mem_rdata,
        input  mem_addr, mem_data, mem_cmd, be0, be1, mem_assert,
        input  rs_wb, rs_ld, rs_tag, rs_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Full/empty come
// straight from the count register, so a pop never frees a slot for a
// push in the same cycle. Payload storage is not reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q];

    // Pointer and count next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared asynchronously so queued entries vanish on reset.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload write; no reset needed because count gates visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lsu_q.sv
// Load/store queue: buffers requests in a FIFO and issues them to a 16-bit
// memory as one beat (bytes, aligned words) or two beats (misaligned words,
// low byte first). A one-cycle completion pulse follows the final beat.
module lsu_q
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic    clk,
    input  logic    a_rst,
    lsu_q_if.slave  bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        width_e            width;
        cmd_e              cmd;
        logic [TAG_W-1:0]  tag;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    req_t              pushReq;
    req_t              head;
    logic              fifoFull;
    logic              fifoEmpty;

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] issueAddr_q;
    logic [7:0]        issueHiByte_q;
    width_e            issueWidth_q;
    cmd_e              issueCmd_q;
    logic [TAG_W-1:0]  issueTag_q;
    logic [7:0]        lowByte_q;

    logic              memAssert_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [15:0]       memData_q;
    logic              memCmd_q;
    logic              be0_q;
    logic              be1_q;

    logic              rsWb_q;
    logic              rsLd_q;
    logic [TAG_W-1:0]  rsTag_q;
    logic [15:0]       rsData_q;
    logic [15:0]       rsData_d;

    logic              isMis;
    logic              beatDone;
    logic              finalDone;
    logic              splitDone;
    logic              popNow;
    logic              firstBe0;
    logic              firstBe1;
    logic [15:0]       firstData;

    // Pack the incoming request into a FIFO entry.
    always_comb begin
        pushReq.addr  = bus.rq_addr;
        pushReq.data  = bus.rq_data;
        pushReq.width = width_e'(bus.rq_width);
        pushReq.cmd   = cmd_e'(bus.rq_cmd);
        pushReq.tag   = bus.rq_tag;
    end

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .a_rst   (a_rst),
        .push_i  (bus.rq_start),
        .data_i  (pushReq),
        .pop_i   (popNow),
        .data_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign isMis     = (issueWidth_q == WIDTH_16) && issueAddr_q[0];
    assign beatDone  = (state_q != ST_IDLE) && bus.mem_rdy;
    assign finalDone = beatDone && ((state_q == ST_BEAT1) || !isMis);
    assign splitDone = beatDone && (state_q == ST_BEAT0) && isMis;
    assign popNow    = !fifoEmpty && ((state_q == ST_IDLE) || finalDone);

    // Lane enables and lane-aligned data for the first beat of the head entry.
    always_comb begin
        firstBe0  = !head.addr[0];
        firstBe1  = head.addr[0] || (head.width == WIDTH_16);
        firstData = {head.data[7:0], head.data[7:0]};
        if ((head.width == WIDTH_16) && !head.addr[0]) begin
            firstData = head.data;
        end
    end

    // Read result assembled at final-beat completion; writes report zero.
    always_comb begin
        rsData_d = 16'h0000;
        if (issueCmd_q == CMD_READ) begin
            if (issueWidth_q == WIDTH_8) begin
                rsData_d = {8'h00, laneSelect(bus.mem_rdata, issueAddr_q[0])};
            end else if (isMis) begin
                rsData_d = {laneSelect(bus.mem_rdata, 1'b0), lowByte_q};
            end else begin
                rsData_d = bus.mem_rdata;
            end
        end
    end

    // Beat sequencing FSM with registered beat-valid and completion pulse.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q     <= ST_IDLE;
            memAssert_q <= 1'b0;
            rsWb_q      <= 1'b0;
        end else begin
            rsWb_q <= finalDone;
            case (state_q)
                ST_IDLE: begin
                    if (popNow) begin
                        state_q     <= ST_BEAT0;
                        memAssert_q <= 1'b1;
                    end
                end
                ST_BEAT0: begin
                    if (splitDone) begin
                        state_q <= ST_BEAT1;
                    end else if (finalDone) begin
                        state_q     <= popNow ? ST_BEAT0 : ST_IDLE;
                        memAssert_q <= popNow;
                    end
                end
                ST_BEAT1: begin
                    if (finalDone) begin
                        state_q     <= popNow ? ST_BEAT0 : ST_IDLE;
                        memAssert_q <= popNow;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    memAssert_q <= 1'b0;
                end
            endcase
        end
    end

    // Issue register, beat outputs and completion payload; none need reset.
    always_ff @(posedge clk) begin
        if (popNow) begin
            issueAddr_q   <= head.addr;
            issueHiByte_q <= head.data[15:8];
            issueWidth_q  <= head.width;
            issueCmd_q    <= head.cmd;
            issueTag_q    <= head.tag;
            memAddr_q     <= head.addr;
            memCmd_q      <= head.cmd;
            be0_q         <= firstBe0;
            be1_q         <= firstBe1;
            memData_q     <= firstData;
        end else if (splitDone) begin
            memAddr_q <= issueAddr_q + ADDR_W'(1);
            be0_q     <= 1'b1;
            be1_q     <= 1'b0;
            memData_q <= {issueHiByte_q, issueHiByte_q};
            lowByte_q <= laneSelect(bus.mem_rdata, 1'b1);
        end
        if (finalDone) begin
            rsTag_q  <= issueTag_q;
            rsLd_q   <= (issueCmd_q == CMD_READ);
            rsData_q <= rsData_d;
        end
    end

    assign bus.rq_hold    = fifoFull;
    assign bus.mem_assert = memAssert_q;
    assign bus.mem_addr   = memAddr_q;
    assign bus.mem_data   = memData_q;
    assign bus.mem_cmd    = memCmd_q;
    assign bus.be0        = be0_q;
    assign bus.be1        = be1_q;
    assign bus.rs_wb      = rsWb_q;
    assign bus.rs_ld      = rsLd_q;
    assign bus.rs_tag     = rsTag_q;
    assign bus.rs_data    = rsData_q;

endmodule
